// File: rtl/cell_fetch_sequencer_pkg.sv
// Shared cell-processing types plus the 3x3 tap offset table used by the
// fetch sequencer and its address generator.
package CellProcessingPkg;

  localparam int CELL_PIX_W = 8;
  localparam int CELL_TAPS  = 9;

  typedef logic [CELL_PIX_W-1:0]           pixel_t;
  typedef logic [CELL_TAPS*CELL_PIX_W-1:0] cellDepth;
  typedef logic [7:0]                      userInput_t;

  typedef enum logic [2:0] {
    OP_PASS   = 3'd0,
    OP_ADD    = 3'd1,
    OP_SUB    = 3'd2,
    OP_MUL    = 3'd3,
    OP_THRESH = 3'd4,
    OP_BLUR   = 3'd5,
    OP_SOBEL  = 3'd6,
    OP_DIFF   = 3'd7
  } opcodes_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  // Row-major from the top-left neighbour: k = (dy+1)*3 + (dx+1).
  localparam int TAP_DX [CELL_TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int TAP_DY [CELL_TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

  function automatic int tap_dx(input logic [3:0] k);
    return (k < 4'd9) ? TAP_DX[k] : 0;
  endfunction

  function automatic int tap_dy(input logic [3:0] k);
    return (k < 4'd9) ? TAP_DY[k] : 0;
  endfunction

endpackage

// File: rtl/cell_fetch_sequencer_addr_gen.sv
// Combinational neighbour address generator: clamps tap k of the cell centred
// at (x, y) to the image and flags whether the raw neighbour was inside it.
module cell_addr_gen
  import CellProcessingPkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic [$clog2(IMG_W)-1:0] x,
  input  logic [$clog2(IMG_H)-1:0] y,
  input  logic [3:0]               k,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     in_bounds
);

  int w_col;
  int w_row;
  int w_col_c;
  int w_row_c;

  always_comb begin
    w_col   = int'(x) + tap_dx(k);
    w_row   = int'(y) + tap_dy(k);
    w_col_c = (w_col < 0) ? 0 : ((w_col >= IMG_W) ? IMG_W - 1 : w_col);
    w_row_c = (w_row < 0) ? 0 : ((w_row >= IMG_H) ? IMG_H - 1 : w_row);
    // Clamping changed nothing exactly when the neighbour lies inside the image.
    in_bounds = (w_col == w_col_c) && (w_row == w_row_c);
    rd_addr   = ADDR_W'(w_row_c * IMG_W + w_col_c);
  end

endmodule

// File: rtl/cell_fetch_sequencer.sv
// Walks an image in raster order, fetching a 3x3 window of images A and B per
// centre pixel. Define CELL_EDGE_ZERO_EN to zero-fill out-of-image taps
// instead of replicating the border.
module cell_fetch_sequencer
  import CellProcessingPkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  opcodes_t                 opcode_in,
  input  userInput_t               userInput_in,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [PIX_W-1:0]         rdataA,
  input  logic [PIX_W-1:0]         rdataB,
  output logic [9*PIX_W-1:0]       cellA,
  output logic [9*PIX_W-1:0]       cellB,
  output opcodes_t                 opcode,
  output userInput_t               userInputA,
  output logic                     cell_valid,
  input  logic                     cell_ready,
  output logic [$clog2(IMG_W)-1:0] cell_x,
  output logic [$clog2(IMG_H)-1:0] cell_y,
  output logic                     busy,
  output logic                     done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

`ifdef CELL_EDGE_ZERO_EN
  localparam bit EDGE_ZERO = 1'b1;
`else
  localparam bit EDGE_ZERO = 1'b0;
`endif

  seq_state_t          r_state;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [3:0]          r_k;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [3:0]          r_rd_tap;
  logic                r_cap_vld;
  logic [3:0]          r_cap_tap;
  logic [8:0]          r_zero_mask;
  logic [9*PIX_W-1:0]  r_cellA;
  logic [9*PIX_W-1:0]  r_cellB;
  opcodes_t            r_opcode;
  userInput_t          r_user;
  logic                r_cell_valid;
  logic                r_busy;
  logic                r_done;

  logic [ADDR_W-1:0]   w_addr;
  logic                w_in_bounds;
  logic                w_issue;
  logic [8:0]          w_slot_we;
  logic [8:0]          w_slot_zero;

  cell_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .x         (r_x),
    .y         (r_y),
    .k         (r_k),
    .rd_addr   (w_addr),
    .in_bounds (w_in_bounds)
  );

  assign w_issue = w_in_bounds | ~EDGE_ZERO;

  // Read data lands one cycle after rd_en; r_cap_* tracks which slot it feeds.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_slot
      assign w_slot_we[gi]   = r_cap_vld && (r_cap_tap == 4'(gi));
      assign w_slot_zero[gi] = (r_state == CAPTURE) && r_zero_mask[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cellA <= '0;
      r_cellB <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (w_slot_zero[i]) begin
          r_cellA[i*PIX_W +: PIX_W] <= '0;
          r_cellB[i*PIX_W +: PIX_W] <= '0;
        end else if (w_slot_we[i]) begin
          r_cellA[i*PIX_W +: PIX_W] <= rdataA;
          r_cellB[i*PIX_W +: PIX_W] <= rdataB;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_k          <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_tap     <= '0;
      r_cap_vld    <= 1'b0;
      r_cap_tap    <= '0;
      r_zero_mask  <= '0;
      r_opcode     <= OP_PASS;
      r_user       <= '0;
      r_cell_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cap_vld <= r_rd_en;
      r_cap_tap <= r_rd_tap;
      if (abort && (r_state != IDLE)) begin
        r_state      <= IDLE;
        r_rd_en      <= 1'b0;
        r_rd_addr    <= '0;
        r_cap_vld    <= 1'b0;
        r_cell_valid <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_opcode <= opcode_in;
              r_user   <= userInput_in;
              r_x      <= '0;
              r_y      <= '0;
              r_k      <= '0;
              r_busy   <= 1'b1;
              r_state  <= FETCH;
            end
          end
          FETCH: begin
            // Taps go out registered, so the last FETCH cycle (k=9) only drains.
            if (r_k == 4'd9) begin
              r_rd_en   <= 1'b0;
              r_rd_addr <= '0;
              r_state   <= CAPTURE;
            end else begin
              r_rd_en   <= w_issue;
              r_rd_addr <= w_issue ? w_addr : '0;
              r_rd_tap  <= r_k;
              for (int i = 0; i < 9; i++) begin
                if (r_k == 4'(i)) r_zero_mask[i] <= ~w_issue;
              end
              r_k <= r_k + 4'd1;
            end
          end
          CAPTURE: begin
            r_cell_valid <= 1'b1;
            r_state      <= PRESENT;
          end
          PRESENT: begin
            if (cell_ready) begin
              r_cell_valid <= 1'b0;
              r_k          <= '0;
              if ((r_x == X_LAST) && (r_y == Y_LAST)) begin
                r_x     <= '0;
                r_y     <= '0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                if (r_x == X_LAST) begin
                  r_x <= '0;
                  r_y <= r_y + 1'b1;
                end else begin
                  r_x <= r_x + 1'b1;
                end
                r_state <= FETCH;
              end
            end
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign cellA      = r_cellA;
  assign cellB      = r_cellB;
  assign opcode     = r_opcode;
  assign userInputA = r_user;
  assign cell_valid = r_cell_valid;
  assign cell_x     = r_x;
  assign cell_y     = r_y;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_cell_fetch_sequencer.sv
// Directed bench for cell_fetch_sequencer on a 4x4 image with synchronous
// one-cycle-latency memories (memA[i]=i, memB[i]=255-i).
module tb_cell_fetch_sequencer;
  import CellProcessingPkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int AW = 4;
`ifdef CELL_EDGE_ZERO_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            cell_ready = 1'b0;
  opcodes_t        opcode_in = OP_PASS;
  userInput_t      userInput_in = '0;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [PW-1:0]   rdataA = '0;
  logic [PW-1:0]   rdataB = '0;
  logic [9*PW-1:0] cellA;
  logic [9*PW-1:0] cellB;
  opcodes_t        opcode;
  userInput_t      userInputA;
  logic            cell_valid;
  logic [1:0]      cell_x;
  logic [1:0]      cell_y;
  logic            busy;
  logic            done;

  logic [PW-1:0]   memA [W*H];
  logic [PW-1:0]   memB [W*H];
  int n_tests  = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;

  cell_fetch_sequencer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .opcode_in(opcode_in), .userInput_in(userInput_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rdataA(rdataA), .rdataB(rdataB),
    .cellA(cellA), .cellB(cellB), .opcode(opcode), .userInputA(userInputA),
    .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_x(cell_x), .cell_y(cell_y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rdataA <= memA[rd_addr];
      rdataB <= memB[rd_addr];
    end
  end

  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (done)  done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int t[9]);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(t[i]);
    return v;
  endfunction

  // Reference window: clamp (or zero) each neighbour of (x, y).
  function automatic logic [71:0] exp_cell(input int x, input int y, input bit is_b);
    logic [71:0] v;
    int col, row, k, p;
    bit oob;
    v = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        k   = (dy + 1) * 3 + (dx + 1);
        col = x + dx;
        row = y + dy;
        oob = (col < 0) || (col >= W) || (row < 0) || (row >= H);
        col = (col < 0) ? 0 : ((col >= W) ? W - 1 : col);
        row = (row < 0) ? 0 : ((row >= H) ? H - 1 : row);
        p   = row * W + col;
        if (is_b) p = 255 - p;
        if (ZERO && oob) p = 0;
        v[k*8 +: 8] = 8'(p);
      end
    end
    return v;
  endfunction

  task automatic pulse_start(input opcodes_t op, input userInput_t u);
    start        = 1'b1;
    opcode_in    = op;
    userInput_in = u;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cycles);
    cycles = 0;
    while (cell_valid !== 1'b1 && cycles < max) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic xfer();
    cell_ready = 1'b1;
    @(negedge clk);
    cell_ready = 1'b0;
  endtask

  initial begin
    int c, rd_snap, d_snap;
    logic [71:0] a_snap;
    int t00[9];
    int t11[9];
    int t11b[9];

    for (int i = 0; i < W*H; i++) begin
      memA[i] = 8'(i);
      memB[i] = 8'(255 - i);
    end
    if (ZERO) t00 = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
    else      t00 = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
    t11 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int i = 0; i < 9; i++) t11b[i] = 255 - t11[i];

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_cellA", cellA, '0);
    check_eq("rst_cellB", cellB, '0);
    check_eq("rst_ctrl", {opcode, userInputA, rd_en, rd_addr, cell_valid, cell_x, cell_y, busy, done}, '0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);

    // Frame 1: full raster with a stall at (2,0) and a stray start at (0,1)
    pulse_start(OP_ADD, 8'h5A);
    check_eq("f1_busy", busy, 1'b1);
    wait_valid(40, c);
    check_eq("f1_latency", c, 11);
    for (int n = 0; n < W*H; n++) begin
      if (n > 0) begin
        wait_valid(40, c);
        check_eq($sformatf("c%0d_valid", n), cell_valid, 1'b1);
      end
      check_eq($sformatf("c%0d_x", n), cell_x, n % W);
      check_eq($sformatf("c%0d_y", n), cell_y, n / W);
      check_eq($sformatf("c%0d_cellA", n), cellA, exp_cell(n % W, n / W, 1'b0));
      check_eq($sformatf("c%0d_cellB", n), cellB, exp_cell(n % W, n / W, 1'b1));
      check_eq($sformatf("c%0d_opcode", n), opcode, OP_ADD);
      check_eq($sformatf("c%0d_user", n), userInputA, 8'h5A);
      if (n == 0) check_eq("c00_taps", cellA, pack9(t00));
      if (n == 5) begin
        check_eq("c11_tapsA", cellA, pack9(t11));
        check_eq("c11_tapsB", cellB, pack9(t11b));
      end
      if (n == 2) begin
        a_snap  = cellA;
        rd_snap = rd_cnt;
        repeat (20) @(negedge clk);
        check_eq("stall_cellA", cellA, a_snap);
        check_eq("stall_xy", {cell_x, cell_y}, {2'd2, 2'd0});
        check_eq("stall_valid", cell_valid, 1'b1);
        check_eq("stall_no_rd", rd_cnt, rd_snap);
      end
      $display("[TB] cell (%0d,%0d) A=%h B=%h", cell_x, cell_y, cellA, cellB);
      xfer();
      if (n == W*H - 1) check_eq("last_done", done, 1'b1);
      else              check_eq($sformatf("c%0d_drop", n), cell_valid, 1'b0);
      if (n == 3) begin
        @(negedge clk);
        pulse_start(OP_SUB, 8'hFF);
      end
    end
    @(negedge clk);
    check_eq("f1_end_done", done, 1'b0);
    check_eq("f1_end_busy", busy, 1'b0);
    check_eq("f1_done_cnt", done_cnt, 1);
    check_eq("f1_rd_cnt", rd_cnt, ZERO ? 100 : 144);

    // Frame 2: abort while fetching (1,2)
    pulse_start(OP_MUL, 8'h11);
    for (int n = 0; n < 9; n++) begin
      wait_valid(40, c);
      check_eq($sformatf("f2_c%0d_valid", n), cell_valid, 1'b1);
      xfer();
    end
    repeat (2) @(negedge clk);
    check_eq("f2_fetch_rd", rd_en, 1'b1);
    check_eq("f2_fetch_xy", {cell_x, cell_y}, {2'd1, 2'd2});
    d_snap = done_cnt;
    abort  = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_outs", {busy, rd_en, cell_valid, done}, 4'b0000);
    repeat (15) @(negedge clk);
    check_eq("abort_no_done", done_cnt, d_snap);
    check_eq("abort_idle_valid", cell_valid, 1'b0);

    // Frame 3: restart after abort begins at (0,0)
    pulse_start(OP_THRESH, 8'h22);
    wait_valid(40, c);
    check_eq("f3_latency", c, 11);
    check_eq("f3_xy", {cell_x, cell_y}, 4'b0000);
    check_eq("f3_opcode", opcode, OP_THRESH);
    check_eq("f3_user", userInputA, 8'h22);
    check_eq("f3_cellA", cellA, pack9(t00));
    xfer();
    wait_valid(40, c);
    check_eq("f3_c1_x", cell_x, 2'd1);

    // Asynchronous reset in the middle of PRESENT
    #2 rst = 1'b0;
    #1;
    check_eq("arst_cellA", cellA, '0);
    check_eq("arst_cellB", cellB, '0);
    check_eq("arst_ctrl", {opcode, userInputA, rd_en, rd_addr, cell_valid, cell_x, cell_y, busy, done}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start(OP_DIFF, 8'h33);
    wait_valid(40, c);
    check_eq("f4_latency", c, 11);
    check_eq("f4_xy", {cell_x, cell_y}, 4'b0000);
    check_eq("f4_cellA", cellA, exp_cell(0, 0, 1'b0));
    check_eq("f4_opcode", opcode, OP_DIFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cell_fetch_sequencer.md
CELL_FETCH_SEQUENCER -- requirements
Module: cell_fetch_sequencer

Interface
REQ-001 Parameters SHALL be: IMG_W, default 64, image width in pixels; IMG_H, default 64, image height in pixels; PIX_W, default 8, pixel width; ADDR_W, default $clog2(IMG_W*IMG_H), memory address width.
REQ-002 Ports SHALL be:
 - clk  in  1  single clock.
 - rst  in  1  asynchronous active-low reset.
 - start  in  1  start one frame.
 - abort  in  1  cancel the current frame.
 - opcode_in  in  opcodes_t  operation for the frame.
 - userInput_in  in  userInput_t  user operand for the frame.
 - rd_en  out  1  memory read strobe.
 - rd_addr  out  ADDR_W  read address, shared by both images.
 - rdataA  in  PIX_W  image A pixel, valid 1 cycle after rd_en.
 - rdataB  in  PIX_W  image B pixel, valid 1 cycle after rd_en.
 - cellA  out  cellDepth  3x3 window of image A.
 - cellB  out  cellDepth  3x3 window of image B.
 - opcode  out  opcodes_t  to the cell processor.
 - userInputA  out  userInput_t  to the cell processor.
 - cell_valid  out  1  cell outputs valid.
 - cell_ready  in  1  consumer accepts.
 - cell_x  out  $clog2(IMG_W)  centre x of the presented cell.
 - cell_y  out  $clog2(IMG_H)  centre y of the presented cell.
 - busy  out  1  frame in progress.
 - done  out  1  one-cycle end-of-frame pulse.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, CAPTURE, PRESENT, DONE.
REQ-004 In IDLE, start=1 SHALL latch opcode_in and userInput_in into opcode and userInputA, set x=0 and y=0, and enter FETCH.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 opcode and userInputA SHALL stay stable until the next accepted start.
REQ-007 FETCH SHALL issue 9 consecutive reads (rd_en=1), tap k=0..8 in row-major order from top-left, at neighbour (x+dx, y+dy), dx and dy each in -1..1.
REQ-008 rd_addr SHALL equal row*IMG_W+col.
REQ-009 The data for tap k SHALL be written to bits [k*PIX_W +: PIX_W] of cellA and of cellB one cycle after that tap's read.
REQ-010 After tap 8 is issued, the FSM SHALL spend one cycle in CAPTURE, then enter PRESENT with cell_valid=1.
REQ-011 cell_valid SHALL rise exactly 11 cycles after the edge that samples start.
REQ-012 In PRESENT, cellA, cellB, cell_x and cell_y SHALL hold stable while cell_valid=1 and cell_ready=0.
REQ-013 A transfer SHALL occur on an edge where cell_valid=1 and cell_ready=1; cell_valid SHALL drop on the following cycle.
REQ-014 After a transfer, x SHALL increment; when x=IMG_W-1, x SHALL wrap to 0 and y SHALL increment; the FSM SHALL then return to FETCH.
REQ-015 The transfer of cell (IMG_W-1, IMG_H-1) SHALL lead to DONE: done=1 for one cycle, then IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Out-of-image neighbours (col<0, col>=IMG_W, row<0, row>=IMG_H) SHALL be clamped to the nearest edge pixel (border replication), unless REQ-023 applies.
REQ-018 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with cell_valid=0, rd_en=0 and no done pulse; abort SHALL take priority over a simultaneous transfer.
REQ-019 rd_en SHALL be 0 outside FETCH.

Reset
REQ-020 rst=0 SHALL asynchronously force IDLE, with these outputs at 0: cellA, cellB, opcode, userInputA, rd_en, rd_addr, cell_valid, cell_x, cell_y, busy, done.
REQ-021 Reset mid-frame SHALL discard all progress; the first start after reset SHALL begin at (0,0).
REQ-022 Reset SHALL be deasserted synchronously to clk by the system; no internal synchronizer is required.

Configuration
REQ-023 With CELL_EDGE_ZERO_EN defined, out-of-image taps SHALL issue no read, and 0 SHALL be written to their cell slots on the capture cycle; the tap cycle count SHALL be unchanged.
REQ-024 Without CELL_EDGE_ZERO_EN, REQ-017 border replication SHALL apply.

Structure
REQ-025 cellDepth (9*PIX_W), pixel_t, opcodes_t and userInput_t SHALL come from CellProcessingPkg; a tap offset table (dx/dy per k) SHALL be added to that package.
REQ-026 Neighbour coordinate clamp/zero and address computation SHALL be in one sub-module, cell_addr_gen (combinational x, y, k -> rd_addr, in_bounds).
REQ-027 The outputs opcode, userInputA, cellA and cellB SHALL connect to the cell processor's image-side ports.

Verification
REQ-028 IMG_W=IMG_H=4, memA[i]=i, memB[i]=255-i, start, cell_ready=1 -> 16 cells; cell (1,1) cellA taps = 0,1,2,4,5,6,8,9,10; done after the 16th transfer.
REQ-029 Cell (0,0), default build -> cellA taps = 0,0,1,0,0,1,4,4,5; with CELL_EDGE_ZERO_EN -> 0,0,0,0,0,1,0,4,5.
REQ-030 cell_ready held 0 for 20 cycles at cell (2,0) -> outputs stable, no rd_en, transfer on the first ready cycle, then fetch of (3,0).
REQ-031 start re-pulsed mid-frame with a new opcode -> opcode unchanged, frame order unaffected.
REQ-032 abort during FETCH of (1,2) -> IDLE next cycle, done never pulses; the next start begins at (0,0).
REQ-033 rst=0 asserted mid-PRESENT between clock edges -> all outputs 0 immediately; start after release -> cell_valid rises 11 cycles later.
